// File: rtl/sec_encoder_awe_30bits_clk_if.sv
// Request/result bundle for the sequential AN-code encoder.
interface sec_encoder_awe_30bits_clk_if #(
   parameter int N_BITS = 31,
   parameter int W_BITS = 38,
   parameter int P_BITS = 6
);
   logic              start;
   logic [N_BITS-1:0] N;
   logic              err_en;
   logic              err_sign;
   logic [P_BITS-1:0] err_pos;
   logic              busy;
   logic              done;
   logic [W_BITS-1:0] W;

   modport master (output start, N, err_en, err_sign, err_pos,
                   input  busy, done, W);
   modport slave  (input  start, N, err_en, err_sign, err_pos,
                   output busy, done, W);
endinterface

// File: rtl/sec_encoder_awe_30bits_clk.sv
// Sequential AN-code encoder: W = A_CONST * N built by shift-add over the bits
// of A_CONST, with optional +/-2^err_pos arithmetic error applied at the end.
module sec_encoder_awe_30bits_clk #(
   parameter int N_BITS  = 31,
   parameter int W_BITS  = 38,
   parameter int A_CONST = 107,
   parameter int A_BITS  = 7,
   parameter int P_BITS  = 6
) (
   input logic clk,
   input logic rst,
   sec_encoder_awe_30bits_clk_if.slave bus
);
   localparam int CNT_W = (A_BITS > 1) ? $clog2(A_BITS) : 1;
   localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A_CONST);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [N_BITS-1:0] n_q, n_d;
   logic              err_en_q, err_en_d;
   logic              err_sign_q, err_sign_d;
   logic [P_BITS-1:0] err_pos_q, err_pos_d;
   logic [W_BITS-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [W_BITS-1:0] w_q, w_d;
   logic              done_q, done_d;
   logic [W_BITS-1:0] err_w;

   // Error term: positions beyond the codeword width inject nothing.
   always_comb begin
      err_w = '0;
      if (err_en_q && (32'(err_pos_q) < W_BITS))
         err_w = W_BITS'(1) << err_pos_q;
   end

   // Next-state and datapath: capture in IDLE, one multiplier bit per MUL cycle,
   // error applied and result registered in FIN.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      err_en_d   = err_en_q;
      err_sign_d = err_sign_q;
      err_pos_d  = err_pos_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      w_d        = w_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               n_d        = bus.N;
               err_en_d   = bus.err_en;
               err_sign_d = bus.err_sign;
               err_pos_d  = bus.err_pos;
               acc_d      = '0;
               cnt_d      = '0;
               state_d    = S_MUL;
            end
         end
         S_MUL: begin
            if (A_VEC[cnt_q])
               acc_d = acc_q + (W_BITS'(n_q) << cnt_q);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(A_BITS - 1))
               state_d = S_FIN;
         end
         S_FIN: begin
            // Modulo 2^W_BITS in both directions: plain wrap-around arithmetic.
            w_d     = err_sign_q ? (acc_q - err_w) : (acc_q + err_w);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         err_en_q   <= 1'b0;
         err_sign_q <= 1'b0;
         err_pos_q  <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         w_q        <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         err_en_q   <= err_en_d;
         err_sign_q <= err_sign_d;
         err_pos_q  <= err_pos_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         w_q        <= w_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.W    = w_q;
endmodule

// File: tb/tb_sec_encoder_awe_30bits_clk.sv
// Directed + random bench for the AN-code encoder with an arithmetic reference
// model and a brute-force single-error AN decoder.
module tb_sec_encoder_awe_30bits_clk;
   localparam longint unsigned A    = 107;
   localparam longint unsigned MASK = (longint'(1) << 38) - 1;
   localparam longint unsigned NMAX = longint'(1) << 31;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   sec_encoder_awe_30bits_clk_if #(.N_BITS(31), .W_BITS(38), .P_BITS(6)) bus ();

   sec_encoder_awe_30bits_clk #(
      .N_BITS(31), .W_BITS(38), .A_CONST(107), .A_BITS(7), .P_BITS(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: codeword plus signed power-of-two error, reduced mod 2^38.
   function automatic longint unsigned model(input longint unsigned n, input bit en,
                                             input bit sg, input int pos);
      longint unsigned w, e;
      w = A * n;
      e = (en && pos < 38) ? (longint'(1) << pos) : 0;
      return (sg ? (w - e) : (w + e)) & MASK;
   endfunction

   // Single-error correction by search: the candidate that is a legal codeword wins.
   function automatic longint unsigned decode(input longint unsigned w);
      longint unsigned c;
      if ((w % A) == 0 && (w / A) < NMAX) return w / A;
      for (int k = 0; k < 38; k++) begin
         for (int s = 0; s < 2; s++) begin
            c = s ? ((w + (longint'(1) << k)) & MASK) : ((w - (longint'(1) << k)) & MASK);
            if ((c % A) == 0 && (c / A) < NMAX) return c / A;
         end
      end
      return '1;
   endfunction

   task automatic run_op(input longint unsigned n, input bit en, input bit sg, input int pos,
                         output longint unsigned w, output int lat);
      bus.N        = 31'(n);
      bus.err_en   = en;
      bus.err_sign = sg;
      bus.err_pos  = 6'(pos);
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.done) begin lat = i; break; end
      end
      w = bus.W;
   endtask

   initial begin
      longint unsigned w, n;
      int lat, pos, ndone, d1, d2, guard;
      bit en, sg;
      longint unsigned wd[2];

      bus.start = 0; bus.N = '0; bus.err_en = 0; bus.err_sign = 0; bus.err_pos = '0;

      // 1. reset then idle
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_busy", bus.busy, 0);
         check("idle_done", bus.done, 0);
         check("idle_W", bus.W, 0);
      end

      // 2. plain products
      run_op(0, 0, 0, 0, w, lat);
      check("n0_lat", lat, 8); check("n0_W", w, 0);
      run_op(1, 0, 0, 0, w, lat);
      check("n1_W", w, 107);
      run_op(2147483647, 0, 0, 0, w, lat);
      check("nmax_W", w, 64'd229780750229);
      tick();
      check("done_pulse", bus.done, 0);
      check("W_held", bus.W, 64'd229780750229);

      // 3. injected errors including wrap below zero
      run_op(1073741823, 1, 0, 3, w, lat);
      check("err_plus3", w, 64'd114890375069);
      run_op(1073741823, 1, 1, 0, w, lat);
      check("err_minus0", w, 64'd114890375060);
      run_op(0, 1, 1, 0, w, lat);
      check("err_wrap", w, 64'd274877906943);
      run_op(12345, 0, 1, 5, w, lat);
      check("err_dis", w, model(12345, 0, 0, 0));

      // 4. start held high: back-to-back acceptance on the done-falling edge
      tick();
      bus.N = 31'd5; bus.err_en = 0; bus.start = 1'b1;
      ndone = 0; d1 = 0; d2 = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.done) begin
            if (ndone < 2) wd[ndone] = bus.W;
            if (ndone == 0) d1 = i; else d2 = i;
            ndone++;
         end
      end
      bus.start = 1'b0;
      check("held_count", ndone, 2);
      check("held_W0", wd[0], 535);
      check("held_W1", wd[1], 535);
      check("held_space", d2 - d1, 9);
      guard = 0;
      while (bus.busy && guard < 20) begin tick(); guard++; end
      check("held_drain", bus.busy, 0);

      // N/err changes while busy are ignored
      bus.N = 31'd5; bus.err_en = 0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      bus.N = 31'd999; bus.err_en = 1; bus.err_pos = 6'd2; bus.start = 1'b1;
      lat = -1;
      for (int i = 3; i <= 20; i++) begin
         tick();
         bus.start = 1'b0;
         if (bus.done) begin lat = i; break; end
      end
      check("midchg_lat", lat, 8);
      check("midchg_W", bus.W, 535);
      tick();

      // 5. reset during MUL step 4
      bus.N = 31'd77; bus.err_en = 0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("pre_rst_busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_W", bus.W, 0);
      tick();
      rst = 1'b0;
      run_op(1073741823, 0, 0, 0, w, lat);
      check("post_rst_lat", lat, 8);
      check("post_rst_W", w, 64'd114890375061);

      // 6. random vectors through model and decoder
      for (int v = 0; v < 40; v++) begin
         n   = longint'($urandom) & (NMAX - 1);
         en  = 1'b1;
         sg  = 1'($urandom);
         pos = (v == 0) ? 40 : int'($urandom_range(0, 37));
         run_op(n, en, sg, pos, w, lat);
         check("rnd_lat", lat, 8);
         check("rnd_W", w, model(n, en, sg, pos));
         check("rnd_dec", decode(w), n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
